// File: rtl/gray_ind_m2p_if.sv
// Signal bundle between the gray/bin indication source, gray_ind_m2p and the downstream pipe.
// Handshake: a method transfers on a cycle where its __ENA and __RDY are both high at the rising edge of CLK.
interface gray_ind_m2p_if #(
  parameter int width = 4
);
  logic             ind_gray__ENA;
  logic [width-1:0] ind_gray_v;
  logic             ind_gray__RDY;
  logic             ind_bin__ENA;
  logic [width-1:0] ind_bin_v;
  logic             ind_bin__RDY;
  logic             pipe_enq__ENA;
  logic [143:0]     pipe_enq_v;
  logic             pipe_enq__RDY;

  modport master (
    output ind_gray__ENA, ind_gray_v, ind_bin__ENA, ind_bin_v, pipe_enq__RDY,
    input  ind_gray__RDY, ind_bin__RDY, pipe_enq__ENA, pipe_enq_v
  );

  modport slave (
    input  ind_gray__ENA, ind_gray_v, ind_bin__ENA, ind_bin_v, pipe_enq__RDY,
    output ind_gray__RDY, ind_bin__RDY, pipe_enq__ENA, pipe_enq_v
  );
endinterface

// File: rtl/gray_ind_m2p.sv
// Turns gray/bin indication method calls into 144-bit pipe messages ({seq, 7'b0, id}, zero-extended value)
// held in a DEPTH-entry FIFO; both methods may fire together, gray taking the lower sequence number.
module gray_ind_m2p #(
  parameter int width = 4,
  parameter int DEPTH = 4
) (
  input logic          CLK,
  input logic          RST,
  gray_ind_m2p_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [143:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] bin_slot;
  logic [CW-1:0] count;
  logic [7:0]    seq;
  logic [7:0]    bin_seq;
  logic          gray_rdy;
  logic          bin_rdy;
  logic          gray_fire;
  logic          bin_fire;
  logic          deq;
  logic [143:0]  gray_msg;
  logic [143:0]  bin_msg;

  // Readiness looks only at the registered count, so a dequeue this cycle frees no slot until next cycle.
  always_comb begin
    gray_rdy  = (count <= CW'(DEPTH - 1));
    bin_rdy   = (count <= CW'(DEPTH - 2));
    gray_fire = bus.ind_gray__ENA && gray_rdy;
    bin_fire  = bus.ind_bin__ENA && bin_rdy;
    deq       = (count != '0) && bus.pipe_enq__RDY;
    bin_slot  = wr_ptr + AW'(gray_fire);
    bin_seq   = seq + 8'(gray_fire);
    gray_msg  = {seq, 7'b0, 1'b0, {(128 - width){1'b0}}, bus.ind_gray_v};
    bin_msg   = {bin_seq, 7'b0, 1'b1, {(128 - width){1'b0}}, bus.ind_bin_v};
  end

  assign bus.ind_gray__RDY = gray_rdy;
  assign bus.ind_bin__RDY  = bin_rdy;
  assign bus.pipe_enq__ENA = deq;
  assign bus.pipe_enq_v    = (count != '0) ? mem[rd_ptr] : '0;

  // Storage carries no reset; an empty FIFO never exposes stale entries.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (gray_fire) mem[wr_ptr] <= gray_msg;
      if (bin_fire)  mem[bin_slot] <= bin_msg;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      seq    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(gray_fire) + AW'(bin_fire);
      rd_ptr <= rd_ptr + AW'(deq);
      count  <= count + CW'(gray_fire) + CW'(bin_fire) - CW'(deq);
      seq    <= seq + 8'(gray_fire) + 8'(bin_fire);
    end
  end
endmodule

// File: tb/tb_gray_ind_m2p.sv
// Directed and randomized bench for gray_ind_m2p; a queue of expected messages doubles as the occupancy model.
module tb_gray_ind_m2p;
  localparam int W = 4;
  localparam int D = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [7:0]   mseq = '0;
  logic [143:0] exp_q[$];
  int   issued;

  gray_ind_m2p_if #(.width(W)) bus ();

  gray_ind_m2p #(.width(W), .DEPTH(D)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] mk_msg(input logic [7:0] s, input logic id, input logic [W-1:0] v);
    mk_msg = {s, 7'b0, id, {(128 - W){1'b0}}, v};
  endfunction

  // One clock cycle: drive, check outputs mid-cycle against the model, update the model, cross the edge.
  task automatic cycle(input logic rst, input logic g, input logic [W-1:0] gv,
                       input logic b, input logic [W-1:0] bv, input logic prdy);
    int sz;
    RST = rst;
    bus.ind_gray__ENA = g;
    bus.ind_gray_v    = gv;
    bus.ind_bin__ENA  = b;
    bus.ind_bin_v     = bv;
    bus.pipe_enq__RDY = prdy;
    #4;
    sz = exp_q.size();
    check("gray_rdy", 144'(bus.ind_gray__RDY), 144'(sz <= D - 1));
    check("bin_rdy", 144'(bus.ind_bin__RDY), 144'(sz <= D - 2));
    check("pipe_ena", 144'(bus.pipe_enq__ENA), 144'((sz != 0) && prdy));
    check("pipe_v", bus.pipe_enq_v, (sz != 0) ? exp_q[0] : 144'd0);
    if (rst) begin
      exp_q.delete();
      mseq = '0;
    end else begin
      if (sz != 0 && prdy) void'(exp_q.pop_front());
      if (g) begin
        exp_q.push_back(mk_msg(mseq, 1'b0, gv));
        mseq++;
      end
      if (b) begin
        exp_q.push_back(mk_msg(mseq, 1'b1, bv));
        mseq++;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input logic prdy, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0, prdy);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1'b1, 1);
    check("drain_empty", 144'(exp_q.size()), 144'd0);
  endtask

  initial begin
    bus.ind_gray__ENA = 1'b0;
    bus.ind_gray_v    = '0;
    bus.ind_bin__ENA  = 1'b0;
    bus.ind_bin_v     = '0;
    bus.pipe_enq__RDY = 1'b0;
    @(posedge CLK);
    #1;
    do_reset();
    do_reset();
    idle(1'b0, 1);
    idle(1'b1, 1);

    // Single gray indication, seen one cycle later with seq 0.
    do_reset();
    cycle(1'b0, 1'b1, 4'hA, 1'b0, '0, 1'b1);
    check("single_msg", bus.pipe_enq_v, {16'h0000, 128'hA});
    idle(1'b1, 2);

    // Gray and bin together: gray first, bin with seq+1.
    do_reset();
    cycle(1'b0, 1'b1, 4'h3, 1'b1, 4'h5, 1'b1);
    check("pair_first", bus.pipe_enq_v, {16'h0000, 128'h3});
    idle(1'b1, 1);
    check("pair_second", bus.pipe_enq_v, {16'h0101, 128'h5});
    idle(1'b1, 2);

    // Fill under back-pressure, then release; the full cycle keeps gray not-ready.
    do_reset();
    for (int i = 0; i < D; i++) cycle(1'b0, 1'b1, W'(i + 6), 1'b0, '0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 1);
    check("full_release_rdy", 144'(bus.ind_gray__RDY), 144'd1);
    cycle(1'b0, 1'b1, 4'hF, 1'b0, '0, 1'b1);
    drain();

    // Reset mid-stream discards buffered entries and restarts seq.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, W'(i + 1), 1'b0, '0, 1'b0);
    do_reset();
    idle(1'b1, 1);
    cycle(1'b0, 1'b1, 4'h9, 1'b0, '0, 1'b1);
    check("post_reset_seq", bus.pipe_enq_v, {16'h0000, 128'h9});
    drain();

    // 257 gray indications under random back-pressure: seq wraps 255 -> 0.
    do_reset();
    issued = 0;
    for (int i = 0; i < 4000 && issued < 257; i++) begin
      logic g;
      g = (exp_q.size() <= D - 1) && ($urandom_range(0, 3) != 0);
      cycle(1'b0, g, W'($urandom_range(0, 15)), 1'b0, '0, 1'($urandom_range(0, 2) != 0));
      if (g) issued++;
    end
    check("issued_257", 144'(issued), 144'd257);
    drain();

    // Mixed gray/bin traffic with random back-pressure.
    for (int i = 0; i < 300; i++) begin
      logic g;
      logic b;
      int   sz;
      sz = exp_q.size();
      g = (sz <= D - 1) && ($urandom_range(0, 1) != 0);
      b = (sz <= D - 2) && ($urandom_range(0, 1) != 0);
      cycle(1'b0, g, W'($urandom_range(0, 15)), b, W'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
